// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the parametrised UART transceiver:
//            frame FSM state encoding, parity mode codes, frame length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    // Receiver walks the same bit sequence as the transmitter.
    typedef tx_state_t rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Whole frame duration in clk cycles.
    function automatic int frame_len(input int data_bits, input int baud_div,
                                     input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * baud_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Loadable baud down-counter. A load starts a period of LOAD cycles
//            (or LOAD/2 with half_i); tick_o pulses for one cycle on the last
//            cycle of the period. Without a reload the counter goes quiet.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            load_i       - start a new period
//            half_i       - qualifies load_i: period is LOAD/2 cycles
//            tick_o       - one-cycle expiry pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int LOAD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int            W       = (LOAD > 1) ? $clog2(LOAD) : 1;
    localparam logic [W-1:0]  FULL_M1 = W'(LOAD - 1);
    localparam logic [W-1:0]  HALF_M1 = W'(LOAD / 2 - 1);

    logic [W-1:0] cnt_q;
    logic         active_q;

    assign tick_o = active_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= half_i ? HALF_M1 : FULL_M1;
            active_q <= 1'b1;
        end else if (tick_o) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q    <= cnt_q - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_xcvr_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr_param
// Purpose  : Parametrised full-duplex UART (DATA_BITS 5..9, BAUD_DIV >= 4,
//            PARITY none/even/odd, 1 or 2 stop bits) with parity, framing,
//            false-start and overrun handling.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            trmt, tx_data            - start pulse and word to send
//            TX, tx_done, tx_busy     - serial out, frame done, mid-frame
//            RX                       - asynchronous serial in
//            clr_rdy                  - clears rdy/perr/ferr/ovr
//            rx_data, rdy             - received word and its valid flag
//            perr, ferr, ovr          - parity / framing / overrun flags
//            loopback (UART_LOOPBACK_EN only) - receive internal TX, hold pin high
// Config   : `define UART_LOOPBACK_EN to add the loopback port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    output logic                 tx_busy,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 perr,
    output logic                 ferr,
    output logic                 ovr
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_xcvr_param: DATA_BITS must be 5..9");
    end
    if (BAUD_DIV < 4) begin : g_bad_baud_div
        $error("uart_xcvr_param: BAUD_DIV must be >= 4");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_xcvr_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_xcvr_param: STOP_BITS must be 1 or 2");
    end
    // Catches 32-bit overflow of the frame length for absurd divisors.
    if (frame_len(DATA_BITS, BAUD_DIV, PARITY, STOP_BITS) <= 0) begin : g_bad_frame_len
        $error("uart_xcvr_param: frame length out of range");
    end

    localparam int             BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0]  LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic           PAR_INV   = (PARITY == PAR_ODD);

    // ------------------------------------------------------------------ TX
    tx_state_t              tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [BW-1:0]          tx_bit_q,   tx_bit_d;
    logic                   tx_q,       tx_d;
    logic                   tx_par_q,   tx_par_d;
    logic                   tx_done_q,  tx_done_d;
    logic                   tx_busy_q,  tx_busy_d;
    logic                   tx_load,    tx_tick;

    uart_baud_cnt #(.LOAD(BAUD_DIV)) u_tx_baud (
        .clk    (clk),
        .rst    (rst),
        .load_i (tx_load),
        .half_i (1'b0),
        .tick_o (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_par_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_par_q   <= tx_par_d;
            tx_done_q  <= tx_done_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = tx_done_q;
        tx_busy_d  = tx_busy_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            IDLE: if (trmt) begin
                tx_state_d = START;
                tx_shift_d = tx_data;
                tx_par_d   = (^tx_data) ^ PAR_INV;
                tx_bit_d   = '0;
                tx_d       = 1'b0;
                tx_done_d  = 1'b0;
                tx_busy_d  = 1'b1;
                tx_load    = 1'b1;
            end
            START: if (tx_tick) begin
                tx_state_d = DATA;
                tx_d       = tx_shift_q[0];
                tx_load    = 1'b1;
            end
            DATA: if (tx_tick) begin
                tx_load = 1'b1;
                if (tx_bit_q == LAST_DATA) begin
                    tx_bit_d = '0;
                    if (HAS_PAR) begin
                        tx_state_d = PAR;
                        tx_d       = tx_par_q;
                    end else begin
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            PAR: if (tx_tick) begin
                tx_state_d = STOP;
                tx_d       = 1'b1;
                tx_load    = 1'b1;
            end
            STOP: if (tx_tick) begin
                if (tx_bit_q == LAST_STOP) begin
                    tx_state_d = IDLE;
                    tx_done_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_load  = 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign tx_done = tx_done_q;
    assign tx_busy = tx_busy_q;

    // Receiver source selection happens ahead of the synchroniser.
    logic rx_in;
`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : RX;
    assign TX    = loopback | tx_q;
`else
    assign rx_in = RX;
    assign TX    = tx_q;
`endif

    // ------------------------------------------------------------------ RX
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t              rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [BW-1:0]          rx_bit_q,   rx_bit_d;
    logic                   rx_par_q,   rx_par_d;
    logic [DATA_BITS-1:0]   rx_data_q,  rx_data_d;
    logic                   rdy_q,  rdy_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q,  ovr_d;
    logic                   rx_load, rx_half, rx_tick;

    uart_baud_cnt #(.LOAD(BAUD_DIV)) u_rx_baud (
        .clk    (clk),
        .rst    (rst),
        .load_i (rx_load),
        .half_i (rx_half),
        .tick_o (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        rx_load    = 1'b0;
        rx_half    = 1'b0;
        // Host clear first so a coincident completion below overrides it.
        if (clr_rdy) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        case (rx_state_q)
            IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = START;
                rx_load    = 1'b1;
                rx_half    = 1'b1;
            end
            START: if (rx_tick) begin
                if (rx_s2_q) begin
                    rx_state_d = IDLE;      // line back high at mid-start: glitch
                end else begin
                    rx_state_d = DATA;
                    rx_bit_d   = '0;
                    rx_load    = 1'b1;
                end
            end
            DATA: if (rx_tick) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                rx_load    = 1'b1;
                if (rx_bit_q == LAST_DATA) begin
                    rx_bit_d = '0;
                    if (HAS_PAR) rx_state_d = PAR;
                    else         rx_state_d = STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            PAR: if (rx_tick) begin
                rx_par_d   = rx_s2_q;
                rx_state_d = STOP;
                rx_load    = 1'b1;
            end
            STOP: if (rx_tick) begin
                rx_state_d = IDLE;
                rx_data_d  = rx_shift_q;
                rdy_d      = 1'b1;
                perr_d     = HAS_PAR && (rx_par_q != ((^rx_shift_q) ^ PAR_INV));
                ferr_d     = !rx_s2_q;
                ovr_d      = rdy_q && !clr_rdy;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovr     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_xcvr_param
// Purpose  : Self-checking bench. u0: default 8N1/2604 with TX wired to RX.
//            u1: 7E2/16 with TX wired to RX. u2: 8O1/16 with RX driven here.
//            Received words are checked through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_xcvr_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst0, rst1, rst2, trmt0, trmt1, trmt2, clr0, clr1, clr2, RX2;
    logic [7:0] tx_data0, tx_data2;
    logic [6:0] tx_data1;
`ifdef UART_LOOPBACK_EN
    logic       lb2;
`endif
    wire        TX0, done0, busy0, rdy0, perr0, ferr0, ovr0;
    wire        TX1, done1, busy1, rdy1, perr1, ferr1, ovr1;
    wire        TX2, done2, busy2, rdy2, perr2, ferr2, ovr2;
    wire [7:0]  rxd0, rxd2;
    wire [6:0]  rxd1;

    uart_xcvr_param #(.DATA_BITS(8), .BAUD_DIV(2604), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst0),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .trmt(trmt0), .tx_data(tx_data0), .TX(TX0), .tx_done(done0), .tx_busy(busy0),
        .RX(TX0), .clr_rdy(clr0), .rx_data(rxd0), .rdy(rdy0), .perr(perr0),
        .ferr(ferr0), .ovr(ovr0));

    uart_xcvr_param #(.DATA_BITS(7), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst1),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .trmt(trmt1), .tx_data(tx_data1), .TX(TX1), .tx_done(done1), .tx_busy(busy1),
        .RX(TX1), .clr_rdy(clr1), .rx_data(rxd1), .rdy(rdy1), .perr(perr1),
        .ferr(ferr1), .ovr(ovr1));

    uart_xcvr_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst2),
`ifdef UART_LOOPBACK_EN
        .loopback(lb2),
`endif
        .trmt(trmt2), .tx_data(tx_data2), .TX(TX2), .tx_done(done2), .tx_busy(busy2),
        .RX(RX2), .clr_rdy(clr2), .rx_data(rxd2), .rdy(rdy2), .perr(perr2),
        .ferr(ferr2), .ovr(ovr2));

    // ------------------------------------------------------------ scoreboard
    typedef struct packed {
        logic [1:0] inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t       sbq[$];
    logic       rdy_p [3];
    logic [8:0] dat_p [3];

    task automatic expect_rx(input int inst, input logic [8:0] d,
                             input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.inst = 2'(inst); e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
        sbq.push_back(e);
    endtask

    task automatic score(input int inst, input logic [8:0] d,
                         input logic pe, input logic fe, input logic ov);
        int idx;
        exp_t e;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].inst == 2'(inst)) idx = k;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL rx%0d_unexpected: got data=%h perr=%b ferr=%b ovr=%b, required no word",
                     inst, d, pe, fe, ov);
        end else begin
            e = sbq[idx];
            sbq.delete(idx);
            if ({d, pe, fe, ov} !== {e.data, e.perr, e.ferr, e.ovr}) begin
                errors++;
                $display("FAIL rx%0d_word: got data=%h perr=%b ferr=%b ovr=%b, required data=%h perr=%b ferr=%b ovr=%b",
                         inst, d, pe, fe, ov, e.data, e.perr, e.ferr, e.ovr);
            end
        end
    endtask

    // A word is presented when rdy rises or rx_data changes while rdy stays high.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic       r;
            logic [8:0] d;
            logic [2:0] f;
            case (i)
                0:       begin r = rdy0; d = {1'b0, rxd0};  f = {perr0, ferr0, ovr0}; end
                1:       begin r = rdy1; d = {2'b0, rxd1};  f = {perr1, ferr1, ovr1}; end
                default: begin r = rdy2; d = {1'b0, rxd2};  f = {perr2, ferr2, ovr2}; end
            endcase
            if (r && (!rdy_p[i] || d != dat_p[i])) score(i, d, f[2], f[1], f[0]);
            rdy_p[i] = r;
            dat_p[i] = d;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic tx_pin(input int s);
        case (s)
            0:       return TX0;
            1:       return TX1;
            default: return TX2;
        endcase
    endfunction

    function automatic logic [1:0] done_busy(input int s);
        case (s)
            0:       return {done0, busy0};
            1:       return {done1, busy1};
            default: return {done2, busy2};
        endcase
    endfunction

    task automatic set_trmt(input int s, input logic v, input logic [8:0] d);
        case (s)
            0:       begin trmt0 = v; tx_data0 = d[7:0]; end
            1:       begin trmt1 = v; tx_data1 = d[6:0]; end
            default: begin trmt2 = v; tx_data2 = d[7:0]; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends one word and checks each bit at its centre plus done/busy timing.
    // n counts edges after the edge that samples trmt (n=1: TX just went low).
    task automatic tx_check(input int s, input logic [8:0] d, input logic [15:0] bits,
                            input int nbits, input int bd, input int f);
        int n;
        @(posedge clk); #1;
        set_trmt(s, 1'b1, d);
        @(posedge clk); #1;
        set_trmt(s, 1'b0, d);
        n = 1;
        for (int k = 0; k < nbits; k++) begin
            while (n < 1 + bd * k + bd / 2) begin @(posedge clk); #1; n++; end
            chk($sformatf("tx%0d_bit%0d", s, k), tx_pin(s), bits[k]);
        end
        while (n < f) begin @(posedge clk); #1; n++; end
        chk($sformatf("tx%0d_done_busy_at_F", s), done_busy(s), 2'b01);
        @(posedge clk); #1;
        chk($sformatf("tx%0d_done_busy_at_F+1", s), done_busy(s), 2'b10);
        chk($sformatf("tx%0d_idle_high", s), tx_pin(s), 1'b1);
    endtask

    // Drives one 8O1 frame (16 cycles/bit) onto RX2; clr_rdy pulses on cycle clr_at.
    task automatic rx_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int clr_at);
        logic [10:0] fb;
        fb = {stp, par, d, 1'b0};
        for (int i = 0; i < 176; i++) begin
            RX2  = fb[i / 16];
            clr2 = (i == clr_at);
            @(posedge clk); #1;
        end
        RX2  = 1'b1;
        clr2 = 1'b0;
    endtask

    task automatic pulse_clr2();
        @(posedge clk); #1; clr2 = 1'b1;
        @(posedge clk); #1; clr2 = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        trmt0 = 1'b0; trmt1 = 1'b0; trmt2 = 1'b0;
        tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0; RX2 = 1'b1;
`ifdef UART_LOOPBACK_EN
        lb2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Reset values
        chk("rst_TX",      TX0,   1'b1);
        chk("rst_tx_done", done0, 1'b0);
        chk("rst_tx_busy", busy0, 1'b0);
        chk("rst_rx_data", rxd0,  8'h00);
        chk("rst_flags",   {rdy0, perr0, ferr0, ovr0}, 4'b0000);
        chk("rst_u2_TX",   TX2,   1'b1);

        // 8N1 / 2604, TX looped to RX: done at cycle 26041
        expect_rx(0, 9'h03A, 1'b0, 1'b0, 1'b0);
        tx_check(0, 9'h03A, 16'({1'b1, 8'h3A, 1'b0}), 10, 2604, 26040);

        // 7E2 / 16: 0,1010101,0,1,1 ; frame 176 cycles
        expect_rx(1, 9'h055, 1'b0, 1'b0, 1'b0);
        tx_check(1, 9'h055, 16'({2'b11, 1'b0, 7'h55, 1'b0}), 11, 16, 176);
        idle(10);

        // 8O1 / 16 receiver: A5 needs parity 1, send 0
        expect_rx(2, 9'h0A5, 1'b1, 1'b0, 1'b0);
        rx_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(20);
        pulse_clr2();
        chk("clr_rdy_clears", {rdy2, perr2, ferr2, ovr2}, 4'b0000);

        // Stop bit low: framing error, parity correct
        expect_rx(2, 9'h03C, 1'b0, 1'b1, 1'b0);
        rx_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(20);
        pulse_clr2();

        // 5-cycle glitch: false start, no word
        RX2 = 1'b0;
        idle(5);
        RX2 = 1'b1;
        idle(40);
        chk("glitch_no_rdy", rdy2, 1'b0);

        // Back-to-back without clr_rdy: overrun
        expect_rx(2, 9'h011, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h11, 1'b1, 1'b1, -1);
        expect_rx(2, 9'h022, 1'b0, 1'b0, 1'b1);
        rx_frame(8'h22, 1'b1, 1'b1, -1);
        idle(10);
        pulse_clr2();

        // clr_rdy on the completion edge of the second word (mid-stop sample
        // lands 171 edges after the start bit: 2 sync + 1 detect + 8 + 10*16)
        expect_rx(2, 9'h011, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h11, 1'b1, 1'b1, -1);
        expect_rx(2, 9'h022, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h22, 1'b1, 1'b1, 170);
        idle(4);
        chk("coincident_clr_rdy_ovr", {rdy2, ovr2}, 2'b10);
        pulse_clr2();

`ifdef UART_LOOPBACK_EN
        // Loopback: receiver fed from internal TX, pin held high
        lb2 = 1'b1;
        expect_rx(2, 9'h05A, 1'b0, 1'b0, 1'b0);
        set_trmt(2, 1'b1, 9'h05A);
        @(posedge clk); #1;
        set_trmt(2, 1'b0, 9'h05A);
        for (int k = 0; k < 12; k++) begin
            idle(16);
            chk($sformatf("loopback_pin_high_%0d", k), TX2, 1'b1);
        end
        lb2 = 1'b0;
        idle(10);
        chk("loopback_rdy", rdy2, 1'b1);
        pulse_clr2();
`endif

        // Reset during data bit 4 of C3 (bit 4 = 0), then a normal frame
        @(posedge clk); #1;
        set_trmt(2, 1'b1, 9'h0C3);
        @(posedge clk); #1;
        set_trmt(2, 1'b0, 9'h0C3);
        idle(87);
        chk("tx_bit4_before_rst", {TX2, busy2}, 2'b01);
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_frame_TX_busy_done", {TX2, busy2, done2}, 3'b100);
        rst2 = 1'b0;
        tx_check(2, 9'h096, 16'({2'b11, 8'h96, 1'b0}), 11, 16, 176);

        idle(10);
        while (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rx%0d_missing: got no word, required data=%h",
                     sbq[0].inst, sbq[0].data);
            void'(sbq.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
